// File: rtl/mult_unit_if.sv
// Execute-stage bundle between the pipeline and the HI/LO multiplier.
// The pipeline side is the master; mult_unit is the slave.
interface mult_unit_if #(parameter int XLEN = 32);
  logic            start;
  logic            is_signed;
  logic [XLEN-1:0] srca;
  logic [XLEN-1:0] srcb;
  logic            hi_we;
  logic            lo_we;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic            mult_active;
  logic            done;

  modport master (
    output start, is_signed, srca, srcb, hi_we, lo_we, wdata,
    input  hi, lo, mult_active, done
  );

  modport slave (
    input  start, is_signed, srca, srcb, hi_we, lo_we, wdata,
    output hi, lo, mult_active, done
  );
endinterface

// File: rtl/mult_unit.sv
// Iterative radix-2 shift-add multiplier owning HI/LO (MULT/MULTU/MTHI/MTLO).
// Signed operands are multiplied as magnitudes and the product negated at the end.
module mult_unit #(
  parameter int XLEN = 32
) (
  input  logic        clk,
  input  logic        reset,
  mult_unit_if.slave  bus
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, BUSY, FIX} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  logic [2*XLEN:0]     acc_q, acc_d;
  logic [XLEN-1:0]     mcand_q, mcand_d;
  logic                neg_q, neg_d;
  logic [XLEN-1:0]     hi_q, hi_d;
  logic [XLEN-1:0]     lo_q, lo_d;
  logic                done_q, done_d;
  logic [XLEN:0]       addend;
  logic [XLEN:0]       sum;
  logic [2*XLEN-1:0]   prod;

  // Magnitude of -2^(XLEN-1) wraps to 0x8000_0000, which is correct as unsigned.
  function automatic logic [XLEN-1:0] magnitude(input logic signed [XLEN-1:0] v,
                                                input logic take_sign);
    if (take_sign && v[XLEN-1]) return -v;
    return v;
  endfunction

  function automatic logic [2*XLEN-1:0] apply_sign(input logic [2*XLEN-1:0] p,
                                                   input logic negate);
    if (negate) return -p;
    return p;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = BUSY;
      BUSY:    if (count_q == CW'(XLEN - 1)) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addend  = acc_q[0] ? {1'b0, mcand_q} : '0;
    sum     = acc_q[2*XLEN:XLEN] + addend;
    prod    = apply_sign(acc_q[2*XLEN-1:0], neg_q);
    count_d = count_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = (state_q == FIX);
    unique case (state_q)
      IDLE: begin
        // MT writes land even when a multiply starts; FIX overwrites them later.
        if (bus.hi_we) hi_d = bus.wdata;
        if (bus.lo_we) lo_d = bus.wdata;
        if (bus.start) begin
          neg_d   = bus.is_signed & (bus.srca[XLEN-1] ^ bus.srcb[XLEN-1]);
          mcand_d = magnitude(bus.srca, bus.is_signed);
          acc_d   = {{(XLEN+1){1'b0}}, magnitude(bus.srcb, bus.is_signed)};
          count_d = '0;
        end
      end
      BUSY: begin
        acc_d   = {1'b0, sum, acc_q[XLEN-1:1]};
        count_d = count_q + 1'b1;
      end
      FIX: begin
        hi_d = prod[2*XLEN-1:XLEN];
        lo_d = prod[XLEN-1:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.mult_active = (state_q != IDLE);
    bus.done        = done_q;
    bus.hi          = hi_q;
    bus.lo          = lo_q;
  end
endmodule
